// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD character-write arbiter.
package lcd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    ACK,
    GAP
  } arb_state_e;

  // Cycles of uninterrupted lcd_ready after a write that count as a silent accept
  localparam int ACCEPT_WIN     = 4;
  localparam int LCD_LINE2_BASE = 16;
  localparam int LCD_COLS       = 16;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector: first asserted request scanning upward
// from last+1 with wrap. Reusable for any shared-resource arbiter.
module lcd_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // Walk from the farthest offset down so the nearest requester wins
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the lcd_controller character-write port.
// Optional handshake watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_char,
  input  logic [5*NUM_REQ-1:0] req_pos,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [7:0]           lcd_char_data,
  output logic [4:0]           lcd_cursor_pos,
  output logic                 lcd_write_enable,
  input  logic                 lcd_ready,
  output logic                 err_timeout
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam int ACC_W = $clog2(ACCEPT_WIN);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 0) begin : g_bad_cfg
    $error("lcd_write_arbiter: parameter out of range");
  end

  arb_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_last, r_grant;
  logic [7:0]       r_char;
  logic [4:0]       r_pos;
  logic [GAP_W-1:0] r_gap;
  logic [ACC_W-1:0] r_acc;
  logic             w_pick_valid;
  logic [ID_W-1:0]  w_pick_idx;
  logic [7:0]       w_pick_char;
  logic [4:0]       w_pick_pos;
  logic             w_grant;
  logic             w_waiting;
  logic             w_timeout;

  lcd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_char = '0;
    w_pick_pos  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_pick_idx) begin
        w_pick_char = req_char[8*i +: 8];
        w_pick_pos  = req_pos[5*i +: 5];
      end
    end
  end

  assign w_grant   = (r_state == IDLE) && lcd_ready && w_pick_valid;
  assign w_waiting = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (w_grant) w_state_nxt = ISSUE;
      ISSUE:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (w_timeout)       w_state_nxt = ACK;
        else if (!lcd_ready) w_state_nxt = WAIT_DONE;
        else if (r_acc == '0) w_state_nxt = ACK;
      end
      WAIT_DONE: if (lcd_ready || w_timeout) w_state_nxt = ACK;
      ACK:       w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (r_gap == '0) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_char  <= '0;
      r_pos   <= '0;
      r_gap   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last  <= w_pick_idx;
        r_grant <= w_pick_idx;
        r_char  <= w_pick_char;
        r_pos   <= w_pick_pos;
      end
      if (r_state == ISSUE) r_acc <= ACC_W'(ACCEPT_WIN - 1);
      else if (r_state == WAIT_BUSY && r_acc != '0) r_acc <= r_acc - 1'b1;
      if (r_state == ACK) r_gap <= GAP_LOAD;
      else if (r_state == GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_err;

  // Loaded with the limit on ISSUE; the last allowed waiting cycle sees 1
  assign w_timeout   = w_waiting && (r_wd <= WD_W'(1));
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ISSUE) r_wd <= WD_W'(TIMEOUT_CYCLES);
      else if (w_waiting && r_wd != '0) r_wd <= r_wd - 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign ack              = (r_state == ACK) ? (NUM_REQ'(1) << r_grant) : '0;
  assign busy             = (r_state != IDLE);
  assign grant_id         = r_grant;
  assign lcd_char_data    = r_char;
  assign lcd_cursor_pos   = r_pos;
  assign lcd_write_enable = (r_state == ISSUE);

endmodule
